cordic_vectoring: RTL
=====================

// Module: cordic_vectoring
// PURPOSE
//  Inverse of the rotation-mode sin/cos CORDIC: takes a signed Cartesian vector (x,y)
//  and returns its angle atan2(y,x) and its gain-compensated magnitude. Iterative:
//  one micro-rotation per clock. Angle uses the same units as the sin/cos block:
//  degrees << 8, so 45 deg = 11520. Sits next to the sin/cos unit for phase recovery.
// PARAMETERS
//  W      16   input data width (signed two's complement)
//  ITER   13   micro-rotations, legal range 1..13; atan table has 13 entries
//  K_INV  155  CORDIC gain compensation, 1/1.6468 in Q0.8
// PORTS
//  CLK        in   1   rising-edge clock
//  reset_n    in   1   asynchronous active-low reset
//  start      in   1   request; sampled only in IDLE
//  x_in       in   W   signed x component, sampled with start
//  y_in       in   W   signed y component, sampled with start
//  busy       out  1   high from the cycle after start is accepted until done
//  done       out  1   one-cycle pulse; results valid from that cycle on
//  angle_out  out  17  unsigned, degrees<<8, range 0..92159 (0 to just under 360 deg)
//  mag_out    out  W+1 unsigned, ~sqrt(x^2+y^2)
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE; busy=0; done=0; angle_out=0; mag_out=0; iteration counter=0.
//   - Takes effect immediately, including mid-computation.
//   - The in-flight job is dropped with no done pulse.
//  Internal widths:
//   - x, y: 18-bit signed (covers pre-negation of -32768 and gain 1.647*sqrt2).
//   - z: 18-bit signed.
//  Atan table e[i] = atan(2^-i) in deg<<8:
//   11520 6801 3593 1824 916 458 229 115 57 29 14 7 4
//  FSM: IDLE -> ITER -> FINAL -> IDLE
//   IDLE:
//    - start=1 loads sign-extended inputs with pre-rotation:
//      - x_in<0: x=-x_in, y=-y_in, z=46080 (180 deg)
//      - else: x=x_in, y=y_in, z=0
//    - i=0; go to ITER.
//   ITER (one step per clock, shifts are arithmetic):
//    - y>=0: x+=y>>>i; y-=x_old>>>i; z+=e[i]
//    - y<0:  x-=y>>>i; y+=x_old>>>i; z-=e[i]
//    - x_old is the pre-update value: all three updates are simultaneous.
//    - After step i=ITER-1, go to FINAL; otherwise i++.
//   FINAL (one cycle):
//    - mag_out = (x*K_INV)>>>8.
//    - angle_out = z<0 ? z+92160 : (z>=92160 ? z-92160 : z).
//    - Special case: x_in=y_in=0 forces angle_out=0, mag_out=0.
//    - done=1 for this cycle only; busy=0; go to IDLE.
//  Latency:
//   - done rises ITER+1 (=14) rising edges after the edge that samples start.
//   - Throughput is one result per ITER+2 cycles (start may be re-asserted the
//     cycle after done).
//  start while busy: ignored (no queueing); x_in/y_in changes while busy have no effect.
//  start held high: a new job is accepted each time the FSM returns to IDLE.
//  Outputs hold their last value until the next FINAL or reset.
//  Accuracy (ITER=13):
//   - |angle error| <= 16 LSB, taken modulo 92160; the wrap near 0/360 is legal.
//   - |mag error| <= 0.5% + 2 LSB.
// TESTING
//  1. x=1000, y=0 -> done at start+14; angle 0 +-16 (mod 92160); mag 1000 +-7.
//  2. x=0,y=1000 -> angle 23040+-16; x=-1000,y=0 -> 46080+-16;
//     x=0,y=-1000 -> 69120+-16; each mag 1000+-7.
//  3. x=1000, y=1000 -> angle 11520+-16, mag 1414+-9;
//     x=-32768, y=-32768 -> angle 57600+-16, mag 46341+-234 (no overflow).
//  4. x=0, y=0 -> angle_out=0, mag_out=0, done pulses once.
//  5. start at cycle 0, start again at cycles 3 and 10 with different data
//     -> exactly one done (cycle 14) carrying the cycle-0 result; busy high on cycles 1-13.
//  6. reset_n low at cycle 6 of a job -> busy/done/outputs 0 immediately;
//     no done pulse; next start after release completes normally.
//  Extra: sweep the angle in 5-degree steps through the sin/cos block, feed cos/sin back
//  into this block, and check the recovered angle = 1280*n +-32 for all n.

Source files
------------

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC returning atan2(y,x) in deg<<8
// and the gain-compensated magnitude of a signed (x,y) vector, one micro-rotation per clock.
module cordic_vectoring #(
   parameter int W     = 16,
   parameter int ITER  = 13,
   parameter int K_INV = 155
) (
   input  logic                CLK,
   input  logic                reset_n,
   input  logic                start,
   input  logic signed [W-1:0] x_in,
   input  logic signed [W-1:0] y_in,
   output logic                busy,
   output logic                done,
   output logic [16:0]         angle_out,
   output logic [W:0]          mag_out
);
   localparam logic signed [17:0] C_ATAN [13] = '{
      18'sd11520, 18'sd6801, 18'sd3593, 18'sd1824, 18'sd916, 18'sd458, 18'sd229,
      18'sd115,   18'sd57,   18'sd29,   18'sd14,   18'sd7,   18'sd4};
   localparam logic signed [17:0] C_FULL = 18'sd92160;
   localparam logic signed [17:0] C_HALF = 18'sd46080;
   localparam logic signed [W+8:0] C_K   = (W+9)'(K_INV);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINAL} state_t;

   state_t             r_state, w_state_nxt;
   logic signed [17:0] r_x, r_y, r_z;
   logic [3:0]         r_i;
   logic               r_zero, r_busy, r_done;
   logic [16:0]        r_angle;
   logic [W:0]         r_mag;

   logic signed [17:0]  w_xs, w_ys, w_e, w_x_ext, w_y_ext, w_zw;
   logic signed [W+8:0] w_prod;
   logic                w_neg, w_last;

   assign w_xs    = r_x >>> r_i;
   assign w_ys    = r_y >>> r_i;
   assign w_e     = C_ATAN[r_i];
   assign w_x_ext = 18'(x_in);
   assign w_y_ext = 18'(y_in);
   assign w_neg   = x_in[W-1];
   assign w_last  = r_i == 4'(ITER-1);
   // x is non-negative after pre-rotation, so the scaled product stays positive
   assign w_prod  = (W+9)'(r_x) * C_K;
   assign w_zw    = r_z[17] ? r_z + C_FULL : (r_z >= C_FULL ? r_z - C_FULL : r_z);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = start ? S_ITER : S_IDLE;
         S_ITER:  w_state_nxt = w_last ? S_FINAL : S_ITER;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_i     <= '0;
         r_zero  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_angle <= '0;
         r_mag   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_state_nxt != S_IDLE;
         r_done  <= r_state == S_FINAL;
         case (r_state)
            S_IDLE: if (start) begin
               r_x    <= w_neg ? -w_x_ext : w_x_ext;
               r_y    <= w_neg ? -w_y_ext : w_y_ext;
               r_z    <= w_neg ? C_HALF : 18'sd0;
               r_i    <= '0;
               r_zero <= x_in == '0 && y_in == '0;
            end
            S_ITER: begin
               r_x <= r_y[17] ? r_x - w_ys : r_x + w_ys;
               r_y <= r_y[17] ? r_y + w_xs : r_y - w_xs;
               r_z <= r_y[17] ? r_z - w_e : r_z + w_e;
               r_i <= w_last ? r_i : r_i + 4'd1;
            end
            default: begin
               r_angle <= r_zero ? '0 : w_zw[16:0];
               r_mag   <= r_zero ? '0 : w_prod[W+8:8];
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign angle_out = r_angle;
   assign mag_out   = r_mag;
endmodule
